mux4_collector: RTL and testbench

Collects four independent lane streams (e.g. PE-column partial sums) into one output stream, the return path of the 4-way lane fan-out. Uses round-robin arbitration with packet locking: once a lane wins, it keeps the output until it delivers a beat marked last. The output is a single registered stage with valid/ready handshake and a 2-bit source tag that matches the fan-out select encoding (0..3 = lane 0..3).

---
 rtl/mux4_collector.sv | 145 ++++++++++++++
 tb/tb_mux4_collector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_collector.sv
`default_nettype none
// ============================================================================
// Module      : mux4_collector
// Description : Four-lane to one-stream collector. Round-robin arbitration
//               with packet locking: a lane that wins keeps the output until
//               it delivers its last beat. The output is a single registered
//               valid/ready stage carrying data, last flag and a source tag.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_collector #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [3:0]       in_valid,
    input  logic [3:0]       in_last,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       out_sel,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;

    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic             last_q;
    logic             valid_q;

    logic             w_load;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_gnt_last;

    // The output register may take a new beat when empty or being drained.
    assign w_load = !valid_q || out_ready;

    // Grant selection: owner only while locked, else rotating search from ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 2'd0;
        if (rst_n && w_load) begin
            if (state_q == ST_LOCK) begin
                w_gnt_vld = in_valid[owner_q];
                w_gnt_idx = owner_q;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!w_gnt_vld && in_valid[ptr_q + 2'(k)]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = ptr_q + 2'(k);
                    end
                end
            end
        end
    end

    // Data/last mux for the granted lane.
    always_comb begin
        w_gnt_data = in0;
        case (w_gnt_idx)
            2'd0:    w_gnt_data = in0;
            2'd1:    w_gnt_data = in1;
            2'd2:    w_gnt_data = in2;
            default: w_gnt_data = in3;
        endcase
        w_gnt_last = in_last[w_gnt_idx];
    end

    assign in_ready = w_gnt_vld ? (4'b0001 << w_gnt_idx) : 4'b0000;

    // Next-state logic: lock on a non-last beat, release and advance on last.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (w_gnt_vld) begin
            if (state_q == ST_ARB) begin
                if (w_gnt_last) begin
                    ptr_d = w_gnt_idx + 2'd1;
                end else begin
                    state_d = ST_LOCK;
                    owner_d = w_gnt_idx;
                end
            end else if (w_gnt_last) begin
                state_d = ST_ARB;
                ptr_d   = owner_q + 2'd1;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Output stage: load granted beat, empty when nothing granted, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            sel_q   <= 2'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (w_load) begin
            if (w_gnt_vld) begin
                out_q   <= w_gnt_data;
                sel_q   <= w_gnt_idx;
                last_q  <= w_gnt_last;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == ST_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_mux4_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_collector
// Description : Directed bench for mux4_collector with a reference arbiter
//               model and a scoreboard of expected output beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_collector;

    localparam int W = 16;

    typedef struct packed {
        logic [1:0]   sel;
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in0, in1, in2, in3;
    logic [3:0]   in_valid, in_last, in_ready;
    logic [W-1:0] out;
    logic [1:0]   out_sel;
    logic         out_last, out_valid, out_ready, busy;

    always #5 clk = ~clk;

    mux4_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] dat [4];
    int           bcnt [4];
    int           plen [4];
    beat_t        sb [$];
    int           plog [$];
    int           e [$];

    bit           m_lock;
    int           m_owner;
    int           m_ptr;
    bit           m_ov;
    bit           m_rst_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        in0 = dat[0];
        in1 = dat[1];
        in2 = dat[2];
        in3 = dat[3];
        for (int k = 0; k < 4; k++) in_last[k] = (bcnt[k] == plen[k] - 1);
    endtask

    // One clock: check DUT against the model, then advance the model.
    task automatic cyc();
        bit         gv;
        int         g;
        bit         ld;
        bit         lb;
        logic [3:0] exp_rdy;
        beat_t      b;
        apply();
        #1;
        gv = 0;
        g  = 0;
        ld = !m_ov || out_ready;
        if (rst_n && ld) begin
            if (m_lock) begin
                gv = in_valid[m_owner];
                g  = m_owner;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    int c;
                    c = (m_ptr + i) % 4;
                    if (!gv && in_valid[c]) begin
                        gv = 1;
                        g  = c;
                    end
                end
            end
        end
        exp_rdy = gv ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (rst_n || m_rst_seen) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("busy", 32'(busy), 32'(m_lock));
        end
        if (rst_n && m_ov) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard observed empty expected pending beat");
            end else begin
                b = sb[0];
                chk("out_sel", 32'(out_sel), 32'(b.sel));
                chk("out_last", 32'(out_last), 32'(b.last));
                chk("out_data", 32'(out), 32'(b.data));
                if (out_ready) begin
                    void'(sb.pop_front());
                    plog.push_back(int'(out_sel));
                end
            end
        end
        lb = gv ? in_last[g] : 1'b0;
        if (gv) sb.push_back('{sel: 2'(g), last: lb, data: dat[g]});
        @(posedge clk);
        if (!rst_n) begin
            m_rst_seen = 1;
            m_lock     = 0;
            m_owner    = 0;
            m_ptr      = 0;
            m_ov       = 0;
            sb.delete();
            for (int k = 0; k < 4; k++) bcnt[k] = 0;
        end else begin
            if (ld) m_ov = gv;
            if (gv) begin
                if (lb) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % 4;
                end else if (!m_lock) begin
                    m_lock  = 1;
                    m_owner = g;
                end
                dat[g]  = dat[g] + 16'h0010;
                bcnt[g] = lb ? 0 : bcnt[g] + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_log(input string tag, input int exp [$]);
        chk({tag, "_len"}, 32'(plog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (i < plog.size()) ? 32'(plog[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
        plog.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dat[k]  = 16'h000A + 16'(k);
            bcnt[k] = 0;
            plen[k] = 1;
        end
        m_lock = 0; m_owner = 0; m_ptr = 0; m_ov = 0; m_rst_seen = 0;
        apply();
        @(negedge clk);

        // Reset held with all lanes valid.
        repeat (3) cyc();
        #1;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        rst_n = 1'b1;

        // Round-robin single beats.
        repeat (6) cyc();
        in_valid = 4'b0000;
        repeat (2) cyc();
        e = '{0, 1, 2, 3, 0, 1};
        chk_log("rr_seq", e);

        // Lane 2 three-beat packet locks out the others.
        plen[2]  = 3;
        in_valid = 4'b1111;
        repeat (6) cyc();
        in_valid = 4'b0000;
        repeat (2) cyc();
        e = '{2, 2, 2, 3, 0, 1};
        chk_log("lock_seq", e);
        plen[2] = 1;

        // Lock with a gap from the owner.
        plen[1]  = 2;
        in_valid = 4'b0010;
        cyc();
        in_valid = 4'b0001;
        repeat (2) cyc();
        in_valid = 4'b0011;
        cyc();
        in_valid = 4'b1001;
        repeat (2) cyc();
        in_valid = 4'b0000;
        repeat (2) cyc();
        e = '{1, 1, 3, 0};
        chk_log("gap_seq", e);
        plen[1] = 1;

        // Backpressure for four cycles, then streaming resumes.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        repeat (4) cyc();
        out_ready = 1'b1;
        repeat (2) cyc();
        in_valid = 4'b0000;
        repeat (2) cyc();
        e = '{1, 2, 3};
        chk_log("bp_seq", e);

        // Reset in the middle of a lane 3 packet.
        plen[3]  = 4;
        in_valid = 4'b1000;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n    = 1'b1;
        plen[3]  = 1;
        in_valid = 4'b1111;
        repeat (2) cyc();
        in_valid = 4'b0000;
        repeat (2) cyc();
        e = '{0, 1};
        chk_log("rstmid_seq", e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
